mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_ctrl_pkg.sv | 67 ++++++
 rtl/mips_multicycle_ctrl_if.sv | 15 +
 rtl/mips_ctrl_decode.sv | 81 ++++++++
 rtl/mips_multicycle_ctrl.sv | 111 +++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the multicycle MIPS controller.
//   - state_t   : controller state enumeration
//   - OP_*      : instruction opcodes (IR[31:26]) recognised by the controller
//   - ALUOP_*, PCSRC_*, SRCB_* : encodings of the 2-bit datapath selects
//   - ctl_t     : packed bundle of every datapath control output
//   - op_legal  : true for opcodes the controller implements
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        RST_IDLE,
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        R_EXEC,
        R_WB,
        BRANCH,
        JUMP,
        ADDI_EX,
        ADDI_WB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control bundle between the controller and datapath.
//   ctl       : all datapath control strobes/selects (ctl_t)
//   mem_ready : memory handshake, transfer completes in a cycle with it high
//   opcode    : IR[31:26]
// master = controller side (drives ctl), slave = datapath side.
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    ctl_t       ctl;
    logic       mem_ready;
    logic [5:0] opcode;

    modport master (output ctl, input mem_ready, input opcode);
    modport slave  (input ctl, output mem_ready, output opcode);
endinterface

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: purely combinational state-to-control decoder.
//   state     : current controller state
//   mem_ready : memory handshake, only consulted in FETCH and MEM_WR
//   bus       : master modport, drives the control bundle
// Anything not set for a state stays 0 (including in RST_IDLE).
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t                        state,
    input  logic                          mem_ready,
    mips_multicycle_ctrl_if.master        bus
);

    always_comb begin
        bus.ctl = '0;
        unique case (state)
            RST_IDLE: ;
            FETCH: begin
                bus.ctl.mem_read  = 1'b1;
                bus.ctl.alu_src_b = SRCB_FOUR;
                bus.ctl.alu_op    = ALUOP_ADD;
                bus.ctl.pc_source = PCSRC_ALU;
                // IR and PC update only on the cycle the fetch completes
                bus.ctl.ir_write  = mem_ready;
                bus.ctl.pc_write  = mem_ready;
            end
            DECODE: begin
                bus.ctl.alu_src_b = SRCB_IMM_SHL2;
                bus.ctl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR, ADDI_EX: begin
                bus.ctl.alu_src_a = 1'b1;
                bus.ctl.alu_src_b = SRCB_IMM;
                bus.ctl.alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                bus.ctl.mem_read = 1'b1;
                bus.ctl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                bus.ctl.reg_write  = 1'b1;
                bus.ctl.mem_to_reg = 1'b1;
                bus.ctl.instr_done = 1'b1;
            end
            MEM_WR: begin
                bus.ctl.mem_write  = 1'b1;
                bus.ctl.i_or_d     = 1'b1;
                bus.ctl.instr_done = mem_ready;
            end
            R_EXEC: begin
                bus.ctl.alu_src_a = 1'b1;
                bus.ctl.alu_src_b = SRCB_B;
                bus.ctl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                bus.ctl.reg_write  = 1'b1;
                bus.ctl.reg_dst    = 1'b1;
                bus.ctl.instr_done = 1'b1;
            end
            BRANCH: begin
                bus.ctl.alu_src_a     = 1'b1;
                bus.ctl.alu_src_b     = SRCB_B;
                bus.ctl.alu_op        = ALUOP_SUB;
                bus.ctl.pc_write_cond = 1'b1;
                bus.ctl.pc_source     = PCSRC_ALUOUT;
                bus.ctl.instr_done    = 1'b1;
            end
            JUMP: begin
                bus.ctl.pc_write   = 1'b1;
                bus.ctl.pc_source  = PCSRC_JUMP;
                bus.ctl.instr_done = 1'b1;
            end
            ADDI_WB: begin
                bus.ctl.reg_write  = 1'b1;
                bus.ctl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main controller (lw, sw, R-type,
// beq, j, addi).
//   clk, rst_n      : clock, asynchronous active-low reset
//   Opcode          : IR[31:26]
//   MemReady        : memory handshake for FETCH, MEM_RD, MEM_WR
//   PCWrite..RegDst : datapath strobes/selects, decoded from the state register
//   PCSource, ALUSrcB, ALUOp : 2-bit datapath selects
//   InstrDone       : one-cycle retire pulse
//   IllegalOp       : sticky unimplemented-opcode flag, cleared only by reset
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       InstrDone,
    output logic       IllegalOp
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   run_q;

    mips_multicycle_ctrl_if bus ();

    assign bus.mem_ready = MemReady;
    assign bus.opcode    = Opcode;

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (MemReady),
        .bus       (bus)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            // Held for one extra edge after rst_n rises (run_q), so the first
            // FETCH lands on the second rising edge after reset release.
            RST_IDLE: state_d = run_q ? FETCH : RST_IDLE;
            FETCH:    if (MemReady) state_d = DECODE;
            DECODE: begin
                unique case (Opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = R_EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default:      state_d = FETCH;
                endcase
                if (!op_legal(Opcode)) illegal_d = 1'b1;
            end
            MEM_ADDR: state_d = (Opcode == OP_SW) ? MEM_WR :
                                (Opcode == OP_LW) ? MEM_RD : FETCH;
            MEM_RD:   if (MemReady) state_d = MEM_WB;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   if (MemReady) state_d = FETCH;
            R_EXEC:   state_d = R_WB;
            R_WB:     state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            ADDI_EX:  state_d = ADDI_WB;
            ADDI_WB:  state_d = FETCH;
            default:  state_d = RST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_IDLE;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            run_q     <= 1'b1;
        end
    end

    assign PCWrite     = bus.ctl.pc_write;
    assign PCWriteCond = bus.ctl.pc_write_cond;
    assign IorD        = bus.ctl.i_or_d;
    assign MemRead     = bus.ctl.mem_read;
    assign MemWrite    = bus.ctl.mem_write;
    assign MemtoReg    = bus.ctl.mem_to_reg;
    assign IRWrite     = bus.ctl.ir_write;
    assign ALUSrcA     = bus.ctl.alu_src_a;
    assign RegWrite    = bus.ctl.reg_write;
    assign RegDst      = bus.ctl.reg_dst;
    assign PCSource    = bus.ctl.pc_source;
    assign ALUSrcB     = bus.ctl.alu_src_b;
    assign ALUOp       = bus.ctl.alu_op;
    assign InstrDone   = bus.ctl.instr_done;
    assign IllegalOp   = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed-vector bench for mips_multicycle_ctrl.
// Expected control vectors are hand-written per state from the state table;
// bit order matches ctl_t: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg
// IRWrite ALUSrcA RegWrite RegDst PCSource[1:0] ALUSrcB[1:0] ALUOp[1:0] InstrDone.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam logic [16:0] E_IDLE    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_FETCH_W = 17'b1_0_0_1_0_0_1_0_0_0_00_01_00_0;
    localparam logic [16:0] E_FETCH_S = 17'b0_0_0_1_0_0_0_0_0_0_00_01_00_0;
    localparam logic [16:0] E_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_0;
    localparam logic [16:0] E_MADDR   = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
    localparam logic [16:0] E_MRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MWB     = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_1;
    localparam logic [16:0] E_MWR_S   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MWR_D   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
    localparam logic [16:0] E_REX     = 17'b0_0_0_0_0_0_0_1_0_0_00_00_10_0;
    localparam logic [16:0] E_RWB     = 17'b0_0_0_0_0_0_0_0_1_1_00_00_00_1;
    localparam logic [16:0] E_BR      = 17'b0_1_0_0_0_0_0_1_0_0_01_00_01_1;
    localparam logic [16:0] E_JMP     = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_1;
    localparam logic [16:0] E_AEX     = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
    localparam logic [16:0] E_AWB     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;

    logic clk;
    logic rst_n;
    logic illegal_op;
    int   n_checks;
    int   n_errors;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (bus.opcode),
        .MemReady    (bus.mem_ready),
        .PCWrite     (bus.ctl.pc_write),
        .PCWriteCond (bus.ctl.pc_write_cond),
        .IorD        (bus.ctl.i_or_d),
        .MemRead     (bus.ctl.mem_read),
        .MemWrite    (bus.ctl.mem_write),
        .MemtoReg    (bus.ctl.mem_to_reg),
        .IRWrite     (bus.ctl.ir_write),
        .ALUSrcA     (bus.ctl.alu_src_a),
        .RegWrite    (bus.ctl.reg_write),
        .RegDst      (bus.ctl.reg_dst),
        .PCSource    (bus.ctl.pc_source),
        .ALUSrcB     (bus.ctl.alu_src_b),
        .ALUOp       (bus.ctl.alu_op),
        .InstrDone   (bus.ctl.instr_done),
        .IllegalOp   (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Applies MemReady for the current cycle, checks the decoded controls,
    // then advances to 2 ns after the next rising edge.
    task automatic cyc(input string tag, input logic mr, input logic [16:0] exp);
        bus.mem_ready = mr;
        #1;
        check(tag, 32'(bus.ctl), 32'(exp));
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = OP_LW;

        #3;
        check("reset_ctl", 32'(bus.ctl), 32'(E_IDLE));
        check("reset_illegal", 32'(illegal_op), 32'd0);

        // release rst_n between edges
        #19;
        rst_n = 1'b1;

        // lw, MemReady=1: IDLE,IDLE,FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB
        bus.opcode = OP_LW;
        cyc("lw_idle0", 1'b1, E_IDLE);
        cyc("lw_idle1", 1'b1, E_IDLE);
        cyc("lw_fetch", 1'b1, E_FETCH_W);
        cyc("lw_decode", 1'b1, E_DECODE);
        cyc("lw_maddr", 1'b1, E_MADDR);
        cyc("lw_mrd", 1'b1, E_MRD);
        cyc("lw_mwb", 1'b1, E_MWB);

        // sw with three MemReady=0 cycles in MEM_WR; MemReady ignored in DECODE/MEM_ADDR
        bus.opcode = OP_SW;
        cyc("sw_fetch", 1'b1, E_FETCH_W);
        cyc("sw_decode_mr0", 1'b0, E_DECODE);
        cyc("sw_maddr_mr0", 1'b0, E_MADDR);
        cyc("sw_mwr_stall0", 1'b0, E_MWR_S);
        cyc("sw_mwr_stall1", 1'b0, E_MWR_S);
        cyc("sw_mwr_stall2", 1'b0, E_MWR_S);
        cyc("sw_mwr_done", 1'b1, E_MWR_D);

        // R-type with a two-cycle fetch stall
        bus.opcode = OP_RTYPE;
        cyc("r_fetch_stall0", 1'b0, E_FETCH_S);
        cyc("r_fetch_stall1", 1'b0, E_FETCH_S);
        cyc("r_fetch", 1'b1, E_FETCH_W);
        cyc("r_decode", 1'b1, E_DECODE);
        cyc("r_exec", 1'b0, E_REX);
        cyc("r_wb", 1'b1, E_RWB);

        // beq
        bus.opcode = OP_BEQ;
        cyc("beq_fetch", 1'b1, E_FETCH_W);
        cyc("beq_decode", 1'b1, E_DECODE);
        cyc("beq_branch", 1'b0, E_BR);

        // addi
        bus.opcode = OP_ADDI;
        cyc("addi_fetch", 1'b1, E_FETCH_W);
        cyc("addi_decode", 1'b1, E_DECODE);
        cyc("addi_ex", 1'b1, E_AEX);
        cyc("addi_wb", 1'b1, E_AWB);
        check("illegal_before", 32'(illegal_op), 32'd0);

        // illegal opcode: back to FETCH without InstrDone, flag sticks
        bus.opcode = 6'b111111;
        cyc("ill_fetch", 1'b1, E_FETCH_W);
        cyc("ill_decode", 1'b1, E_DECODE);
        check("illegal_set", 32'(illegal_op), 32'd1);
        bus.opcode = OP_J;
        cyc("j_fetch", 1'b1, E_FETCH_W);
        cyc("j_decode", 1'b1, E_DECODE);
        cyc("j_jump", 1'b1, E_JMP);
        check("illegal_sticky", 32'(illegal_op), 32'd1);

        // reset asserted mid MEM_RD stall
        bus.opcode = OP_LW;
        cyc("rst_fetch", 1'b1, E_FETCH_W);
        cyc("rst_decode", 1'b1, E_DECODE);
        cyc("rst_maddr", 1'b1, E_MADDR);
        cyc("rst_mrd_stall", 1'b0, E_MRD);
        bus.mem_ready = 1'b0;
        #1;
        check("rst_pre_mrd", 32'(bus.ctl), 32'(E_MRD));
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", 32'(bus.ctl), 32'(E_IDLE));
        check("rst_async_illegal", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #2;
        check("rst_held_ctl", 32'(bus.ctl), 32'(E_IDLE));
        rst_n = 1'b1;
        cyc("rst_idle0", 1'b1, E_IDLE);
        cyc("rst_idle1", 1'b1, E_IDLE);
        cyc("rst_refetch", 1'b1, E_FETCH_W);
        check("rst_illegal_after", 32'(illegal_op), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
